// File: rtl/relu_pkg.sv
// rtl/relu_pkg.sv - shared ReLU definitions used by the forward and backward blocks
package relu_pkg;

  localparam int RELU_DATA_W = 32;

  // Derivative of ReLU at zero is taken as 0, so only strictly positive inputs pass.
  function automatic logic relu_mask(input logic signed [RELU_DATA_W-1:0] x);
    return (x > 0);
  endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// rtl/relu_mask_fifo.sv - 1-bit synchronous FIFO holding forward-pass ReLU masks
module relu_mask_fifo
  import relu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             wr_data,
  input  logic             pop,
  output logic             rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  mem;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Registered storage only, so a freshly written bit is visible one cycle later.
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/relu_backward.sv
// rtl/relu_backward.sv - gates incoming gradients with the stored forward ReLU mask
module relu_backward
  import relu_pkg::*;
#(
  parameter int DATA_W = RELU_DATA_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fwd_valid,
  output logic              fwd_ready,
  input  logic [DATA_W-1:0] fwd_din,
  input  logic              bwd_valid,
  output logic              bwd_ready,
  input  logic [DATA_W-1:0] bwd_grad,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_grad,
  output logic [CNT_W-1:0]  mask_count,
  output logic              underrun
);

  logic mask_in;
  logic mask_out;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  if (DATA_W == RELU_DATA_W) begin : g_shared_mask
    assign mask_in = relu_mask(fwd_din);
  end else begin : g_local_mask
    assign mask_in = ($signed(fwd_din) > 0);
  end

  assign fwd_ready = !fifo_full;
  assign bwd_ready = !fifo_empty && (!out_valid || out_ready);
  assign push      = fwd_valid && fwd_ready;
  assign pop       = bwd_valid && bwd_ready;

  relu_mask_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_mask_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .push    (push),
    .wr_data (mask_in),
    .pop     (pop),
    .rd_data (mask_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (mask_count)
  );

  // Single output register; a pop only happens when it is empty or draining.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      out_grad  <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_grad  <= mask_out ? bwd_grad : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      underrun <= 1'b0;
    end else if (bwd_valid && fifo_empty) begin
      underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_relu_backward.sv
// tb/tb_relu_backward.sv - directed vector bench for relu_backward
module tb_relu_backward;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              fwd_valid;
  logic              fwd_ready;
  logic [DATA_W-1:0] fwd_din;
  logic              bwd_valid;
  logic              bwd_ready;
  logic [DATA_W-1:0] bwd_grad;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_grad;
  logic [CNT_W-1:0]  mask_count;
  logic              underrun;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic signed [DATA_W-1:0] din;
    logic signed [DATA_W-1:0] grad;
    logic        [DATA_W-1:0] exp_out;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs [NVEC];

  logic mq [$];
  logic signed [DATA_W-1:0] d;
  logic [DATA_W-1:0] exp_g;

  always #5 clk = ~clk;

  relu_backward #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_din    (fwd_din),
    .bwd_valid  (bwd_valid),
    .bwd_ready  (bwd_ready),
    .bwd_grad   (bwd_grad),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_grad   (out_grad),
    .mask_count (mask_count),
    .underrun   (underrun)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{din: 5,             grad: 100,           exp_out: 100};
    vecs[1] = '{din: -3,            grad: 200,           exp_out: 0};
    vecs[2] = '{din: 0,             grad: 300,           exp_out: 0};
    vecs[3] = '{din: 7,             grad: 400,           exp_out: 400};
    vecs[4] = '{din: 32'h7fffffff,  grad: -1,            exp_out: 32'hffffffff};
    vecs[5] = '{din: 32'h80000000,  grad: 55,            exp_out: 0};
    vecs[6] = '{din: 1,             grad: 32'h80000000,  exp_out: 32'h80000000};

    rst = 1'b1; flush = 1'b0; fwd_valid = 1'b0; fwd_din = '0;
    bwd_valid = 1'b0; bwd_grad = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_fwd_ready", fwd_ready, 1);
    chk("rst_bwd_ready", bwd_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_grad", out_grad, 0);
    chk("rst_mask_count", mask_count, 0);
    chk("rst_underrun", underrun, 0);

    // Basic gating from the vector table
    for (int i = 0; i < NVEC; i++) begin
      fwd_valid = 1'b1; fwd_din = vecs[i].din;
      step();
    end
    fwd_valid = 1'b0;
    chk("basic_count_full", mask_count, NVEC);
    out_ready = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      bwd_valid = 1'b1; bwd_grad = vecs[i].grad;
      #1;
      chk($sformatf("basic_bwd_ready_%0d", i), bwd_ready, 1);
      step();
      chk($sformatf("basic_out_valid_%0d", i), out_valid, 1);
      chk($sformatf("basic_out_grad_%0d", i), out_grad, vecs[i].exp_out);
      chk($sformatf("basic_count_%0d", i), mask_count, NVEC - 1 - i);
    end
    bwd_valid = 1'b0;
    step();
    chk("basic_drain_valid", out_valid, 0);
    chk("basic_drain_grad_hold", out_grad, vecs[NVEC-1].exp_out);
    chk("basic_no_underrun", underrun, 0);

    // Full FIFO and blocked 17th beat
    fwd_valid = 1'b1; fwd_din = 1;
    for (int i = 0; i < DEPTH; i++) step();
    chk("full_count", mask_count, DEPTH);
    chk("full_fwd_ready", fwd_ready, 0);
    step();
    chk("full_17th_blocked", mask_count, DEPTH);
    fwd_valid = 1'b0;
    bwd_valid = 1'b1; bwd_grad = 9;
    step();
    bwd_valid = 1'b0;
    chk("full_pop_count", mask_count, DEPTH - 1);
    chk("full_pop_fwd_ready", fwd_ready, 1);
    chk("full_pop_grad", out_grad, 9);
    bwd_valid = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) step();
    bwd_valid = 1'b0;
    chk("full_drained", mask_count, 0);
    step();

    // Backpressure: one accept into the output register, then stall
    fwd_valid = 1'b1;
    fwd_din = 1;  step();
    fwd_din = 2;  step();
    fwd_din = -5; step();
    fwd_valid = 1'b0;
    out_ready = 1'b0;
    bwd_valid = 1'b1; bwd_grad = 11;
    step();
    bwd_grad = 22;
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_grad", out_grad, 11);
    chk("bp_bwd_ready_low", bwd_ready, 0);
    for (int i = 0; i < 3; i++) step();
    chk("bp_hold_grad", out_grad, 11);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_count", mask_count, 2);
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bwd_ready, 1);
    step();
    chk("bp_second_grad", out_grad, 22);
    bwd_grad = 33;
    step();
    chk("bp_third_grad", out_grad, 0);
    chk("bp_third_valid", out_valid, 1);
    bwd_valid = 1'b0;
    step();
    chk("bp_end_valid", out_valid, 0);
    chk("bp_end_count", mask_count, 0);

    // Simultaneous push and pop at count 8, crossing pointer wrap
    fwd_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d = (k % 3 == 1) ? -k : k;
      fwd_din = d; mq.push_back(d > 0);
      step();
    end
    chk("sim_prefill", mask_count, 8);
    bwd_valid = 1'b1;
    for (int k = 8; k < 18; k++) begin
      d = (k % 3 == 1) ? -k : k;
      fwd_din = d; bwd_grad = 1000 + k;
      exp_g = mq.pop_front() ? DATA_W'(1000 + k) : '0;
      mq.push_back(d > 0);
      step();
      chk($sformatf("sim_count_%0d", k), mask_count, 8);
      chk($sformatf("sim_grad_%0d", k), out_grad, exp_g);
    end
    fwd_valid = 1'b0;
    for (int k = 18; k < 26; k++) begin
      bwd_grad = 1000 + k;
      exp_g = mq.pop_front() ? DATA_W'(1000 + k) : '0;
      step();
      chk($sformatf("sim_drain_grad_%0d", k), out_grad, exp_g);
    end
    bwd_valid = 1'b0;
    chk("sim_drain_count", mask_count, 0);
    step();

    // Underrun on empty FIFO
    bwd_valid = 1'b1; bwd_grad = -42;
    #1;
    chk("ur_bwd_ready", bwd_ready, 0);
    step();
    bwd_valid = 1'b0;
    chk("ur_flag", underrun, 1);
    chk("ur_no_output", out_valid, 0);
    fwd_valid = 1'b1; fwd_din = 3;
    step();
    fwd_valid = 1'b0;
    bwd_valid = 1'b1; bwd_grad = 5;
    step();
    bwd_valid = 1'b0;
    chk("ur_later_grad", out_grad, 5);
    chk("ur_sticky", underrun, 1);
    step();

    // Flush mid-operation
    fwd_valid = 1'b1; fwd_din = 4;
    for (int i = 0; i < 7; i++) step();
    fwd_valid = 1'b0;
    out_ready = 1'b0;
    bwd_valid = 1'b1; bwd_grad = 77;
    step();
    bwd_valid = 1'b0;
    chk("fl_pre_count", mask_count, 6);
    chk("fl_pre_valid", out_valid, 1);
    flush = 1'b1; fwd_valid = 1'b1; bwd_valid = 1'b1;
    step();
    flush = 1'b0; fwd_valid = 1'b0; bwd_valid = 1'b0;
    chk("fl_count", mask_count, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_out_grad", out_grad, 0);
    chk("fl_fwd_ready", fwd_ready, 1);
    chk("fl_underrun", underrun, 0);
    chk("fl_bwd_ready", bwd_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
